// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: operation codes, FSM states
// and datapath widths.
package alu_pkg;

    localparam int RESULT_W  = 64;
    localparam int OPERAND_W = 32;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_ISSUE2,
        ST_WAIT,
        ST_CAPTURE,
        ST_RESP,
        ST_DRAIN
    } issuer_state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_resp_reg.sv
// Response holding register: loads a result, then holds data/tag/err stable
// until the downstream valid/ready handshake completes.
module alu_resp_reg
    import alu_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [RESULT_W-1:0] load_data,
    input  logic [TAG_W-1:0]    load_tag,
    input  logic                load_err,
    input  logic                resp_ready,
    output logic                resp_valid,
    output logic [RESULT_W-1:0] resp_data,
    output logic [TAG_W-1:0]    resp_tag,
    output logic                resp_err
);

    // The FSM never loads while a response is pending, so load needs no stall guard.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_tag   <= '0;
            resp_err   <= 1'b0;
        end else if (load) begin
            resp_valid <= 1'b1;
            resp_data  <= load_data;
            resp_tag   <= load_tag;
            resp_err   <= load_err;
        end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Command-side initiator for the multicycle ALU: issues one request at a time,
// tracks busy to find the final result and returns it with the request tag.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int         TAG_W   = 4,
    parameter int         TIMEOUT = 63,
    parameter logic [2:0] NOP_OP  = OP_NOP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_op,
    input  logic [OPERAND_W-1:0] req_a,
    input  logic [OPERAND_W-1:0] req_b,
    input  logic [TAG_W-1:0]     req_tag,
    output logic [2:0]           alu_operation,
    output logic [OPERAND_W-1:0] alu_operandA,
    output logic [OPERAND_W-1:0] alu_operandB,
    output logic                 alu_operation_valid,
    input  logic [RESULT_W-1:0]  alu_result,
    input  logic                 alu_busy,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [RESULT_W-1:0]  resp_data,
    output logic [TAG_W-1:0]     resp_tag,
    output logic                 resp_err
);

    issuer_state_t      state;
    logic [2:0]         op_q;
    logic [TAG_W-1:0]   tag_q;
    logic               seen_busy;
    logic [7:0]         wait_cnt;
    logic               wait_done;
    logic               wait_expired;

    logic               load;
    logic [RESULT_W-1:0] load_data;
    logic [TAG_W-1:0]   load_tag;
    logic               load_err;

    assign wait_done    = seen_busy && !alu_busy;
    assign wait_expired = (wait_cnt == 8'(TIMEOUT - 1));

    // The ALU operand outputs double as the operand latch for ISSUE2.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= alu_busy ? ST_DRAIN : ST_IDLE;
            req_ready           <= 1'b0;
            alu_operation       <= NOP_OP;
            alu_operandA        <= '0;
            alu_operandB        <= '0;
            alu_operation_valid <= 1'b0;
            op_q                <= NOP_OP;
            tag_q               <= '0;
            seen_busy           <= 1'b0;
            wait_cnt            <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        op_q      <= req_op;
                        tag_q     <= req_tag;
                        if (is_legal_op(req_op)) begin
                            state               <= ST_ISSUE;
                            alu_operation       <= req_op;
                            alu_operandA        <= req_a;
                            alu_operandB        <= req_b;
                            alu_operation_valid <= 1'b1;
                        end else begin
                            state <= ST_RESP;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (op_q == OP_DIV) begin
                        state <= ST_ISSUE2;
                    end else begin
                        alu_operation       <= NOP_OP;
                        alu_operation_valid <= 1'b0;
                        seen_busy           <= 1'b0;
                        wait_cnt            <= '0;
                        state               <= (op_q == OP_MUL) ? ST_WAIT : ST_CAPTURE;
                    end
                end
                ST_ISSUE2: begin
                    alu_operation       <= NOP_OP;
                    alu_operation_valid <= 1'b0;
                    seen_busy           <= 1'b0;
                    wait_cnt            <= '0;
                    state               <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (alu_busy) begin
                        seen_busy <= 1'b1;
                    end
                    // Capture is checked first so a falling busy beats the timeout.
                    if (wait_done || wait_expired) begin
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_CAPTURE: begin
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_valid && resp_ready) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!alu_busy) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // A multicycle result is taken the cycle busy falls, so the response
    // appears one cycle later, matching the add/sub CAPTURE path.
    always_comb begin
        load      = 1'b0;
        load_data = alu_result;
        load_tag  = tag_q;
        load_err  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid && req_ready && !is_legal_op(req_op)) begin
                    load      = 1'b1;
                    load_data = '0;
                    load_tag  = req_tag;
                    load_err  = 1'b1;
                end
            end
            ST_CAPTURE: begin
                load = 1'b1;
            end
            ST_WAIT: begin
                if (wait_done) begin
                    load = 1'b1;
                end else if (wait_expired) begin
                    load      = 1'b1;
                    load_data = '0;
                    load_err  = 1'b1;
                end
            end
            default: begin
                load = 1'b0;
            end
        endcase
    end

    alu_resp_reg #(
        .TAG_W(TAG_W)
    ) u_resp_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_data  (load_data),
        .load_tag   (load_tag),
        .load_err   (load_err),
        .resp_ready (resp_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .resp_err   (resp_err)
    );

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer with a behavioural multicycle ALU model
// (34 busy cycles for mul/div, optional stuck-busy fault).
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'b000;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [3:0]  req_tag = '0;
    logic [2:0]  alu_operation;
    logic [31:0] alu_operandA;
    logic [31:0] alu_operandB;
    logic        alu_operation_valid;
    logic [63:0] alu_result = '0;
    logic        alu_busy;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_data;
    logic [3:0]  resp_tag;
    logic        resp_err;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  tag;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hs_cyc = 0;
    int   first_cyc = 0;
    int   last_resp_cyc = 0;
    bit   resp_seen = 0;

    logic        busy_int = 1'b0;
    logic        stuck = 1'b0;
    int          busy_cnt = 0;
    logic [63:0] pend = '0;
    int          nop_viol = 0;
    int          touch = 0;
    int          div_cycles = 0;

    assign alu_busy = busy_int || stuck;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_cmd_issuer dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_op              (req_op),
        .req_a               (req_a),
        .req_b               (req_b),
        .req_tag             (req_tag),
        .alu_operation       (alu_operation),
        .alu_operandA        (alu_operandA),
        .alu_operandB        (alu_operandB),
        .alu_operation_valid (alu_operation_valid),
        .alu_result          (alu_result),
        .alu_busy            (alu_busy),
        .resp_valid          (resp_valid),
        .resp_ready          (resp_ready),
        .resp_data           (resp_data),
        .resp_tag            (resp_tag),
        .resp_err            (resp_err)
    );

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        logic signed [63:0] p;
        logic [31:0] q;
        logic [31:0] r;
        sa = a;
        sbv = b;
        case (op)
            OP_ADD: return {32'b0, 32'(a + b)};
            OP_SUB: return {32'b0, 32'(a - b)};
            OP_MUL: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return p;
            end
            OP_DIV: begin
                q = sa / sbv;
                r = sa % sbv;
                return {r, q};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // ALU model: samples commands mid-cycle, updates just after the rising edge.
    initial begin
        logic        sv;
        logic [2:0]  sop;
        logic [31:0] sa;
        logic [31:0] sbv;
        forever begin
            @(negedge clk);
            sv = alu_operation_valid;
            sop = alu_operation;
            sa = alu_operandA;
            sbv = alu_operandB;
            if (alu_busy && !sv && sop != OP_NOP) nop_viol++;
            if (sv || sop != OP_NOP) touch++;
            if (sv && sop == OP_DIV) div_cycles++;
            @(posedge clk);
            #1;
            if (busy_int) begin
                if (busy_cnt == 0) begin
                    busy_int = 1'b0;
                    alu_result = pend;
                end else begin
                    busy_cnt--;
                end
            end else if (sv) begin
                if (sop == OP_MUL || sop == OP_DIV) begin
                    busy_int = 1'b1;
                    busy_cnt = 33;
                    pend = ref_result(sop, sa, sbv);
                end else begin
                    alu_result = ref_result(sop, sa, sbv);
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every response handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                resp_seen = 0;
            end else begin
                if (req_valid && req_ready) hs_cyc = cyc;
                if (resp_valid && !resp_seen) begin
                    first_cyc = cyc;
                    resp_seen = 1;
                end
                if (resp_valid && resp_ready) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected resp", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("resp_data", resp_data, e.data);
                        checkOutput("resp_tag", 64'(resp_tag), 64'(e.tag));
                        checkOutput("resp_err", 64'(resp_err), 64'(e.err));
                        checkOutput("latency", 64'(first_cyc - hs_cyc), 64'(e.lat));
                    end
                    resp_seen = 0;
                    last_resp_cyc = cyc;
                end
            end
        end
    end

    task automatic sendRequest(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("req_ready wait", 64'(req_ready), 64'd1);
        req_op = op;
        req_a = a;
        req_b = b;
        req_tag = tag;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                                 input logic [63:0] exp_data, input logic exp_err, input int exp_lat);
        exp_t e;
        e.data = exp_data;
        e.tag = tag;
        e.err = exp_err;
        e.lat = exp_lat;
        sb.push_back(e);
        sendRequest(op, a, b, tag);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((sb.size() != 0 || resp_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("resp done", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        int n;
        int base;
        int drain_viol;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset req_ready", 64'(req_ready), 64'd0);
        checkOutput("reset resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("reset resp_data", resp_data, 64'd0);
        checkOutput("reset resp_tag/err", {59'd0, resp_tag, resp_err}, 64'd0);
        checkOutput("reset alu_operation", 64'(alu_operation), 64'(OP_NOP));
        checkOutput("reset operands", {alu_operandA, alu_operandB}, 64'd0);
        checkOutput("reset op_valid", 64'(alu_operation_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] add / sub");
        applyStimulus(OP_ADD, 32'd5, 32'd7, 4'd3, 64'd12, 1'b0, 3);
        waitIdle();
        applyStimulus(OP_SUB, 32'd3, 32'd5, 4'd1, 64'h0000_0000_FFFF_FFFE, 1'b0, 3);
        waitIdle();

        $display("[TB] mul / div");
        nop_viol = 0;
        applyStimulus(OP_MUL, -32'sd3, 32'd7, 4'd4, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 37);
        waitIdle();
        checkOutput("mul nop in wait", 64'(nop_viol), 64'd0);
        div_cycles = 0;
        applyStimulus(OP_DIV, 32'd100, 32'd7, 4'd7, {32'd2, 32'd14}, 1'b0, 37);
        waitIdle();
        checkOutput("div issue cycles", 64'(div_cycles), 64'd2);

        $display("[TB] backpressure and back-to-back");
        resp_ready = 1'b0;
        applyStimulus(OP_ADD, 32'd10, 32'd20, 4'd5, 64'd30, 1'b0, 3);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall valid", 64'(resp_valid), 64'd1);
            checkOutput("stall data", resp_data, 64'd30);
            checkOutput("stall tag", 64'(resp_tag), 64'd5);
            checkOutput("stall req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        begin
            exp_t e;
            e.data = 64'h0000_0000_FFFF_FFFE;
            e.tag = 4'd6;
            e.err = 1'b0;
            e.lat = 3;
            sb.push_back(e);
        end
        req_op = OP_SUB;
        req_a = 32'd3;
        req_b = 32'd5;
        req_tag = 4'd6;
        req_valid = 1'b1;
        resp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("back2back accept", 64'(hs_cyc), 64'(last_resp_cyc + 1));
        waitIdle();

        $display("[TB] illegal op");
        base = touch;
        applyStimulus(3'b101, 32'd1, 32'd2, 4'd11, 64'd0, 1'b1, 1);
        waitIdle();
        checkOutput("illegal alu touch", 64'(touch - base), 64'd0);

        $display("[TB] random ops");
        for (int i = 0; i < 6; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (rop == OP_DIV) rb = $urandom_range(1, 1000);
            applyStimulus(rop, ra, rb, 4'(i), ref_result(rop, ra, rb), 1'b0, (rop < OP_MUL) ? 3 : 37);
            waitIdle();
        end

        $display("[TB] timeout");
        @(posedge clk);
        #1;
        stuck = 1'b1;
        applyStimulus(OP_MUL, 32'd3, 32'd4, 4'd2, 64'd0, 1'b1, 65);
        waitIdle();
        stuck = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        $display("[TB] reset drain");
        sendRequest(OP_MUL, 32'd9, 32'd9, 4'd8);
        while (cyc < hs_cyc + 10) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drain_viol = 0;
        n = 0;
        while (alu_busy && n < 100) begin
            @(negedge clk);
            if (alu_busy && (req_ready || resp_valid)) drain_viol++;
            n++;
        end
        checkOutput("drain ready low", 64'(drain_viol), 64'd0);
        n = 0;
        while (!req_ready && n < 5) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain ready rise", 64'(req_ready), 64'd1);
        checkOutput("drain resp discarded", 64'(resp_valid), 64'd0);
        @(posedge clk);
        #1;
        applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'd2, 4'd15, 64'd1, 1'b0, 3);
        waitIdle();
        checkOutput("nop violations", 64'(nop_viol), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
